// File: rtl/i2s_audio_tx.sv
// i2s_audio_tx: scales/saturates the mixed TONE sample to 16 bits, buffers it in a
// 2-entry FIFO and serialises it as mono I2S (same word on L and R), one word per frame.
module i2s_audio_tx #(
  parameter int unsigned BCLK_HALF = 8,
  parameter int unsigned SHIFT     = 15
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] TONE,
  input  logic        TONE_VALID,
  output logic        TONE_READY,
  output logic        FRAME_REQ,
  output logic        UNDERRUN,
  output logic        AUD_BCLK,
  output logic        AUD_DACLRCK,
  output logic        AUD_DACDAT
);

  localparam int unsigned DIV_W  = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned BIT_W  = 6;

  logic [DIV_W-1:0]  div_q, div_d;
  logic              bclk_q, bclk_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              lrck_q, lrck_d;
  logic              dat_q, dat_d;
  logic              frame_req_q, frame_req_d;
  logic              underrun_q, underrun_d;
  logic              ready_q, ready_d;
  logic [WORD_W-1:0] mem_q [2];
  logic [WORD_W-1:0] mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic [WORD_W-1:0] play_q, play_d;
  logic [WORD_W-1:0] last_q, last_d;

  logic              div_end_c;
  logic              fall_c;
  logic              frame_start_c;
  logic              push_c;
  logic              pop_c;
  logic signed [31:0] tone_s_c;
  logic [WORD_W-1:0] word_c;
  logic [4:0]        idx_c;
  logic [3:0]        sel_c;

  // Scale by arithmetic shift, then saturate to the signed 16-bit range
  always_comb begin
    tone_s_c = $signed(TONE) >>> SHIFT;
    word_c   = tone_s_c[WORD_W-1:0];
    if (tone_s_c > 32'sd32767) begin
      word_c = 16'h7FFF;
    end else if (tone_s_c < -32'sd32768) begin
      word_c = 16'h8000;
    end
  end

  // Divider, bit counter, serial outputs, FIFO and frame-start next-state logic
  always_comb begin
    div_d       = DIV_W'(div_q + 1'b1);
    bclk_d      = bclk_q;
    bit_cnt_d   = bit_cnt_q;
    lrck_d      = lrck_q;
    dat_d       = dat_q;
    frame_req_d = 1'b0;
    underrun_d  = 1'b0;
    play_d      = play_q;
    last_d      = last_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    idx_c       = 5'd0;
    sel_c       = 4'd0;

    div_end_c     = (div_q == DIV_W'(BCLK_HALF - 1));
    fall_c        = div_end_c & bclk_q;
    frame_start_c = fall_c & (bit_cnt_q == 6'd63);
    push_c        = TONE_VALID & ready_q;
    pop_c         = frame_start_c & (count_q != 2'd0);

    if (div_end_c) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
    end

    // Frame start latches the word to play; an empty FIFO repeats the last word
    if (frame_start_c) begin
      frame_req_d = 1'b1;
      if (pop_c) begin
        play_d = mem_q[rd_ptr_q];
        last_d = mem_q[rd_ptr_q];
      end else begin
        play_d     = last_q;
        underrun_d = 1'b1;
      end
    end

    // Serial data changes only on BCLK falling edges; slot 0 of each half is the I2S delay
    if (fall_c) begin
      bit_cnt_d = BIT_W'(bit_cnt_q + 1'b1);
      lrck_d    = bit_cnt_d[5];
      idx_c     = bit_cnt_d[4:0];
      sel_c     = 4'(5'd16 - idx_c);
      if ((idx_c >= 5'd1) && (idx_c <= 5'd16)) begin
        dat_d = play_d[sel_c];
      end else begin
        dat_d = 1'b0;
      end
    end

    if (push_c) begin
      mem_d[wr_ptr_q] = word_c;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_c) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push_c, pop_c})
      2'b10:   count_d = 2'(count_q + 2'd1);
      2'b01:   count_d = 2'(count_q - 2'd1);
      default: count_d = count_q;
    endcase

    ready_d = (count_d < 2'd2);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      div_q       <= '0;
      bclk_q      <= 1'b0;
      bit_cnt_q   <= 6'd63;
      lrck_q      <= 1'b0;
      dat_q       <= 1'b0;
      frame_req_q <= 1'b0;
      underrun_q  <= 1'b0;
      ready_q     <= 1'b0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      play_q      <= '0;
      last_q      <= '0;
    end else begin
      div_q       <= div_d;
      bclk_q      <= bclk_d;
      bit_cnt_q   <= bit_cnt_d;
      lrck_q      <= lrck_d;
      dat_q       <= dat_d;
      frame_req_q <= frame_req_d;
      underrun_q  <= underrun_d;
      ready_q     <= ready_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      play_q      <= play_d;
      last_q      <= last_d;
    end
  end

  assign TONE_READY  = ready_q;
  assign FRAME_REQ   = frame_req_q;
  assign UNDERRUN    = underrun_q;
  assign AUD_BCLK    = bclk_q;
  assign AUD_DACLRCK = lrck_q;
  assign AUD_DACDAT  = dat_q;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// tb_i2s_audio_tx: directed bench with a scoreboard queue of expected 16-bit words.
module tb_i2s_audio_tx;

  logic        CLK;
  logic        RESET_N;
  logic [31:0] TONE;
  logic        TONE_VALID;
  logic        TONE_READY;
  logic        FRAME_REQ;
  logic        UNDERRUN;
  logic        AUD_BCLK;
  logic        AUD_DACLRCK;
  logic        AUD_DACDAT;

  i2s_audio_tx dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .TONE        (TONE),
    .TONE_VALID  (TONE_VALID),
    .TONE_READY  (TONE_READY),
    .FRAME_REQ   (FRAME_REQ),
    .UNDERRUN    (UNDERRUN),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_DACLRCK (AUD_DACLRCK),
    .AUD_DACDAT  (AUD_DACDAT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          total;
  int          bad;
  int          tcount;
  int          last_fs;
  bit          have_fs;
  bit          just_pushed;
  logic [15:0] sb [$];
  logic [15:0] cur_exp;
  logic [15:0] play_m;
  logic [15:0] last_m;

  logic [31:0] sat_tone [6] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_8000,
                                32'h3FFF_8000, 32'hC000_0000, 32'h0004_0000};
  logic [15:0] sat_word [6] = '{16'h7FFF, 16'h8000, 16'hFFFF,
                                16'h7FFF, 16'h8000, 16'h0008};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; a handshake seen before the edge completes on it and enters the scoreboard
  task automatic tick();
    logic xfer;
    xfer = TONE_VALID && TONE_READY;
    @(negedge CLK);
    tcount++;
    just_pushed = xfer;
    if (xfer) begin
      sb.push_back(cur_exp);
      TONE_VALID = 1'b0;
    end
  endtask

  task automatic push(input logic [31:0] tone, input logic [15:0] exp);
    TONE       = tone;
    cur_exp    = exp;
    TONE_VALID = 1'b1;
  endtask

  // Wait for FRAME_REQ, then apply the frame-start pop to the model
  task automatic wait_frame();
    int   n;
    int   avail;
    logic exp_un;
    n = 0;
    while (FRAME_REQ !== 1'b1 && n < 1100) begin
      tick();
      n++;
    end
    if (FRAME_REQ !== 1'b1) begin
      check("frame_timeout", 64'd0, 64'd1);
      return;
    end
    avail = sb.size() - (just_pushed ? 1 : 0);
    if (avail > 0) begin
      play_m = sb.pop_front();
      last_m = play_m;
      exp_un = 1'b0;
    end else begin
      play_m = last_m;
      exp_un = 1'b1;
    end
    check("underrun_at_start", 64'(UNDERRUN), 64'(exp_un));
    if (have_fs) check("frame_period", 64'(tcount - last_fs), 64'd1024);
    have_fs = 1'b1;
    last_fs = tcount;
  endtask

  // Sample DACDAT/LRCK at every BCLK rise of the current frame
  task automatic check_bits();
    logic [63:0] dat_v;
    logic [63:0] lr_v;
    logic [63:0] bclk_v;
    int          c;
    int          strays;
    dat_v  = '0;
    lr_v   = '0;
    bclk_v = '0;
    strays = 0;
    c = tcount - last_fs;
    while (c < 1016) begin
      tick();
      c = tcount - last_fs;
      if (FRAME_REQ !== 1'b0 || UNDERRUN !== 1'b0) strays++;
      if (c >= 8 && ((c - 8) % 16) == 0) begin
        int b;
        b = (c - 8) / 16;
        dat_v[63-b]  = AUD_DACDAT;
        lr_v[63-b]   = AUD_DACLRCK;
        bclk_v[63-b] = AUD_BCLK;
      end
    end
    check("serial_data", dat_v, {1'b0, play_m, 15'h0, 1'b0, play_m, 15'h0});
    check("lrck_pattern", lr_v, 64'h0000_0000_FFFF_FFFF);
    check("bclk_high_at_sample", bclk_v, {64{1'b1}});
    check("stray_pulses", 64'(strays), 64'd0);
  endtask

  // Reset for 3 cycles, release, and verify start-up timing
  task automatic reset_and_start();
    int t0;
    RESET_N    = 1'b0;
    TONE_VALID = 1'b0;
    tick();
    check("reset_outputs",
          64'({TONE_READY, FRAME_REQ, UNDERRUN, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT}), 64'd0);
    tick();
    tick();
    RESET_N = 1'b1;
    sb.delete();
    last_m  = '0;
    have_fs = 1'b0;
    t0      = tcount;
    for (int n = 1; n <= 15; n++) begin
      tick();
      if (n == 1) begin
        check("ready_after_release", 64'(TONE_READY), 64'd1);
        check("bclk_low_c1", 64'(AUD_BCLK), 64'd0);
      end
      if (n == 7)  check("bclk_low_c7", 64'(AUD_BCLK), 64'd0);
      if (n == 8)  check("bclk_rise_c8", 64'(AUD_BCLK), 64'd1);
      if (n == 15) check("bclk_high_c15", 64'(AUD_BCLK), 64'd1);
    end
    wait_frame();
    check("first_fall_cycle", 64'(tcount - t0), 64'd16);
    check("bclk_fall_c16", 64'(AUD_BCLK), 64'd0);
  endtask

  initial begin
    RESET_N     = 1'b0;
    TONE        = '0;
    TONE_VALID  = 1'b0;
    total       = 0;
    bad         = 0;
    tcount      = 0;
    last_fs     = 0;
    have_fs     = 1'b0;
    just_pushed = 1'b0;
    cur_exp     = '0;
    play_m      = '0;
    last_m      = '0;

    // Reset and first (underrun) frame
    reset_and_start();
    check_bits();

    // Basic word 0x0001
    push(32'h0000_8000, 16'h0001);
    wait_frame();
    check_bits();

    // Saturation and boundary conversions
    for (int i = 0; i < 6; i++) begin
      push(sat_tone[i], sat_word[i]);
      wait_frame();
      check_bits();
    end

    // FIFO full: third sample held until the next frame-start pop
    wait_frame();
    push(32'h0001_0000, 16'h0002);
    tick();
    push(32'h0002_8000, 16'h0005);
    tick();
    check("ready_low_when_full", 64'(TONE_READY), 64'd0);
    push(32'h0003_0000, 16'h0006);
    tick();
    check("ready_low_held", 64'(TONE_READY), 64'd0);
    check_bits();
    check("held_still_waiting", 64'(TONE_VALID), 64'd1);
    wait_frame();
    check("ready_after_pop", 64'(TONE_READY), 64'd1);
    check_bits();
    wait_frame();
    check_bits();
    wait_frame();
    check_bits();

    // Underrun repeats the last word
    push(32'h091A_0000, 16'h1234);
    wait_frame();
    check_bits();
    wait_frame();
    check("underrun_word_repeat", 64'(play_m), 64'h1234);
    check_bits();

    // Reset mid-frame at bit 20 with two samples buffered
    wait_frame();
    push(32'h0005_0000, 16'h000A);
    tick();
    push(32'h0006_0000, 16'h000C);
    tick();
    check("ready_low_before_reset", 64'(TONE_READY), 64'd0);
    while (tcount - last_fs < 328) tick();
    check("bclk_high_before_reset", 64'(AUD_BCLK), 64'd1);
    reset_and_start();
    check_bits();
    wait_frame();
    check_bits();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
